// File: rtl/multicycle_controller.sv
// Control unit for the multi-cycle RV32I datapath: Moore main FSM plus
// combinational ALU and immediate decoders. The FSM state is visible on the state port.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       branch, pc_update;
  logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    branch        = 1'b0;
    pc_update     = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          default: begin
            state_d     = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset kills every write enable at once, even though the FSM sits in FETCH.
  assign pc_write      = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
  assign ir_write      = ~reset & ir_write_raw;
  assign mem_write     = ~reset & mem_write_raw;
  assign reg_write     = ~reset & reg_write_raw;
  assign illegal_instr = ~reset & illegal_raw;
  assign state         = state_q;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each driven cycle pushes its
// hand-computed control vector; a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
    S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .reg_write(reg_write), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  // Field order: state, pc_write, adr_src, mem_write, ir_write, result_src,
  // alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal_instr.
  function automatic logic [W-1:0] vec(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
      input logic [2:0] alu, input logic rw, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
  endfunction

  // Drive one cycle: inputs set just after posedge, expectation queued, then advance.
  task automatic cyc(input string nm, input logic rst, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z, input logic [W-1:0] e);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, e;
      string nm;
      got = {state, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal_instr};
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, got, e);
      end
    end
  end

  initial begin
    reset = 1'b1; op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    // Reset held 3 cycles with lw on op
    for (int i = 0; i < 3; i++)
      cyc("reset_hold", 1, OP_LW, 3'b010, 0, 0, vec(S_FETCH,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    // lw: 5 cycles
    cyc("lw_fetch",   0, OP_LW, 3'b010, 0, 1, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("lw_decode",  0, OP_LW, 3'b010, 0, 1, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("lw_memadr",  0, OP_LW, 3'b010, 0, 0, vec(S_MEMADR,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("lw_memread", 0, OP_LW, 3'b010, 0, 1, vec(S_MEMREAD,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_memwb",   0, OP_LW, 3'b010, 0, 0, vec(S_MEMWB,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));
    // sw: 4 cycles, imm_src S throughout
    cyc("sw_fetch",    0, OP_SW, 3'b010, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("sw_decode",   0, OP_SW, 3'b010, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    cyc("sw_memadr",   0, OP_SW, 3'b010, 0, 0, vec(S_MEMADR,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    cyc("sw_memwrite", 0, OP_SW, 3'b010, 0, 1, vec(S_MEMWRITE,0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    // R-type sub
    cyc("sub_fetch",  0, OP_R, 3'b000, 1, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("sub_decode", 0, OP_R, 3'b000, 1, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("sub_execr",  0, OP_R, 3'b000, 1, 0, vec(S_EXECR,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
    cyc("sub_aluwb",  0, OP_R, 3'b000, 1, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    // addi with funct7b5 set stays add
    cyc("addi_fetch",  0, OP_I, 3'b000, 1, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("addi_decode", 0, OP_I, 3'b000, 1, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("addi_execi",  0, OP_I, 3'b000, 1, 0, vec(S_EXECI,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("addi_aluwb",  0, OP_I, 3'b000, 1, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    // R-type and / or / slt / xor-slot (add)
    cyc("and_fetch",  0, OP_R, 3'b111, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("and_decode", 0, OP_R, 3'b111, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("and_execr",  0, OP_R, 3'b111, 0, 0, vec(S_EXECR,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,0));
    cyc("and_aluwb",  0, OP_R, 3'b111, 0, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    cyc("or_fetch",   0, OP_R, 3'b110, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("or_decode",  0, OP_R, 3'b110, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("or_execr",   0, OP_R, 3'b110, 0, 0, vec(S_EXECR,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0,0));
    cyc("or_aluwb",   0, OP_R, 3'b110, 0, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    cyc("slti_fetch",  0, OP_I, 3'b010, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("slti_decode", 0, OP_I, 3'b010, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("slti_execi",  0, OP_I, 3'b010, 0, 0, vec(S_EXECI,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0,0));
    cyc("slti_aluwb",  0, OP_I, 3'b010, 0, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    cyc("xor_fetch",  0, OP_R, 3'b100, 1, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("xor_decode", 0, OP_R, 3'b100, 1, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("xor_execr",  0, OP_R, 3'b100, 1, 0, vec(S_EXECR,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
    cyc("xor_aluwb",  0, OP_R, 3'b100, 1, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    // Branches: beq/bne with zero both ways; zero toggled in non-branch states
    for (int k = 0; k < 4; k++) begin
      logic [2:0] f3;
      logic       z, take;
      f3   = (k >= 2) ? 3'b001 : 3'b000;
      z    = k[0];
      take = z ^ f3[0];
      cyc("br_fetch",  0, OP_BR, f3, 0, ~z, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      cyc("br_decode", 0, OP_BR, f3, 0, ~z, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      cyc("br_branch", 0, OP_BR, f3, 0, z,  vec(S_BRANCH,take,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
    end
    // jal
    cyc("jal_fetch",  0, OP_JAL, 3'b000, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0,0));
    cyc("jal_decode", 0, OP_JAL, 3'b000, 0, 1, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0));
    cyc("jal_jal",    0, OP_JAL, 3'b000, 0, 0, vec(S_JAL,1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
    cyc("jal_aluwb",  0, OP_JAL, 3'b000, 0, 0, vec(S_ALUWB,0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1,0));
    // Illegal opcode: 2 cycles, flag only in DECODE
    cyc("ill_fetch",  0, OP_BAD, 3'b000, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("ill_decode", 0, OP_BAD, 3'b000, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));
    // sw interrupted by reset in MEMWRITE
    cyc("swr_fetch",  0, OP_SW, 3'b010, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("swr_decode", 0, OP_SW, 3'b010, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    cyc("swr_memadr", 0, OP_SW, 3'b010, 0, 0, vec(S_MEMADR,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    // Now in MEMWRITE: assert reset mid-cycle, before the monitor samples
    exp_q.push_back(vec(S_FETCH,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    name_q.push_back("swr_abort");
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("swr_hold",   1, OP_SW, 3'b010, 0, 0, vec(S_FETCH,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("post_fetch", 0, OP_LW, 3'b010, 0, 0, vec(S_FETCH,1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("post_decode",0, OP_LW, 3'b010, 0, 0, vec(S_DECODE,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
